// File: rtl/wb_commit_queue_pkg.sv
// Shared types for the WB commit queue: the retirement write-enable struct,
// the stored commit entry, and the helper that builds an entry with Wen already masked.
package wb_commit_queue_pkg;

    typedef struct packed {
        logic RFWr;
        logic HIWr;
        logic LOWr;
        logic CP0Wr;
    } RegsWrType;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } commit_entry_t;

    localparam logic [3:0] WEN_ALL  = 4'hF;
    localparam logic [3:0] WEN_NONE = 4'h0;

    // Writes to $zero are not architectural, so they are stored as "no write".
    function automatic commit_entry_t make_entry(
        input logic [31:0] pc,
        input logic [31:0] instr,
        input logic [4:0]  dst,
        input logic [31:0] result,
        input logic        rfwr
    );
        commit_entry_t e;
        e.pc    = pc;
        e.instr = instr;
        if (rfwr && (dst != 5'd0)) begin
            e.wen   = WEN_ALL;
            e.wnum  = dst;
            e.wdata = result;
        end else begin
            e.wen   = WEN_NONE;
            e.wnum  = 5'd0;
            e.wdata = 32'd0;
        end
        return e;
    endfunction

endpackage

// File: rtl/wb_commit_queue_fifo.sv
// Circular storage for commit entries: head/tail pointers, occupancy counter
// and the next-state occupancy used by the stall register in the top level.
module commit_fifo
    import wb_commit_queue_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter type T     = commit_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   next_occupancy,
    output logic                     full,
    output logic                     empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_OCC = (AW+1)'(DEPTH);
    localparam logic [AW:0]    OCC_ZERO = (AW+1)'(0);
    localparam logic [AW:0]    OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ZERO = AW'(0);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    T              mem_r [DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [AW:0]   occ_r;
    logic [AW:0]   occ_next_s;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (occ_r == OCC_ZERO);
    assign full      = (occ_r == FULL_OCC);
    assign do_pop_s  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign do_push_s = push & (~full | do_pop_s);

    // Next-state occupancy from the effective push/pop pair.
    always_comb begin
        occ_next_s = occ_r;
        case ({do_push_s, do_pop_s})
            2'b10:   occ_next_s = occ_r + OCC_ONE;
            2'b01:   occ_next_s = occ_r - OCC_ONE;
            default: occ_next_s = occ_r;
        endcase
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_r <= PTR_ZERO;
            tail_r <= PTR_ZERO;
            occ_r  <= OCC_ZERO;
        end else begin
            if (do_push_s) tail_r <= tail_r + PTR_ONE;
            if (do_pop_s)  head_r <= head_r + PTR_ONE;
            occ_r <= occ_next_s;
        end
    end

    // Entry storage; contents are don't-care until covered by occupancy.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[tail_r] <= din;
    end

    assign dout           = empty ? T'('0) : mem_r[head_r];
    assign next_occupancy = occ_next_s;

endmodule

// File: rtl/wb_commit_queue.sv
// Commit queue after the WB register: buffers retirements into a valid/ready
// trace stream, requests a pipeline stall near full and counts commits.
module wb_commit_queue
    import wb_commit_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AFULL_THR = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_Valid,
    input  logic [31:0] WB_PC,
    input  logic [31:0] WB_Instr,
    input  logic [4:0]  WB_Dst,
    input  logic [31:0] WB_Result,
    input  RegsWrType   WB_RegsWrType,
    input  logic        Commit_Ready,
    output logic        Commit_Valid,
    output logic [31:0] Commit_PC,
    output logic [31:0] Commit_Instr,
    output logic [3:0]  Commit_Wen,
    output logic [4:0]  Commit_Wnum,
    output logic [31:0] Commit_Wdata,
    output logic        Commit_Stall,
    output logic        Commit_Overflow,
    output logic [63:0] Commit_Count
);

    localparam int          AW    = $clog2(DEPTH);
    localparam logic [AW:0] THR_C = (AW+1)'(AFULL_THR);

    commit_entry_t wb_entry_s;
    commit_entry_t head_s;
    logic [AW:0]   next_occ_s;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          stall_r;
    logic          overflow_r;
    logic [63:0]   count_r;
    logic          unused_regs_s;

    assign unused_regs_s = ^{WB_RegsWrType.HIWr, WB_RegsWrType.LOWr, WB_RegsWrType.CP0Wr};

    assign wb_entry_s = make_entry(WB_PC, WB_Instr, WB_Dst, WB_Result, WB_RegsWrType.RFWr);
    assign pop_s      = Commit_Valid & Commit_Ready;

    commit_fifo #(
        .DEPTH (DEPTH),
        .T     (commit_entry_t)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (WB_Valid),
        .pop            (pop_s),
        .din            (wb_entry_s),
        .dout           (head_s),
        .next_occupancy (next_occ_s),
        .full           (full_s),
        .empty          (empty_s)
    );

    // Stall, sticky overflow flag and the commit counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_r    <= 1'b0;
            overflow_r <= 1'b0;
            count_r    <= 64'd0;
        end else begin
            stall_r <= (next_occ_s >= THR_C);
            if (WB_Valid && full_s && !pop_s) overflow_r <= 1'b1;
            if (pop_s) count_r <= count_r + 64'd1;
        end
    end

    assign Commit_Valid    = ~empty_s;
    assign Commit_PC       = head_s.pc;
    assign Commit_Instr    = head_s.instr;
    assign Commit_Wen      = head_s.wen;
    assign Commit_Wnum     = head_s.wnum;
    assign Commit_Wdata    = head_s.wdata;
    assign Commit_Stall    = stall_r;
    assign Commit_Overflow = overflow_r;
    assign Commit_Count    = count_r;

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue: reset, masking, stall/overflow, wrap order, reset mid-stream.
module tb_wb_commit_queue;
    import wb_commit_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_Valid;
    logic [31:0] WB_PC;
    logic [31:0] WB_Instr;
    logic [4:0]  WB_Dst;
    logic [31:0] WB_Result;
    RegsWrType   WB_RegsWrType;
    logic        Commit_Ready;
    logic        Commit_Valid;
    logic [31:0] Commit_PC;
    logic [31:0] Commit_Instr;
    logic [3:0]  Commit_Wen;
    logic [4:0]  Commit_Wnum;
    logic [31:0] Commit_Wdata;
    logic        Commit_Stall;
    logic        Commit_Overflow;
    logic [63:0] Commit_Count;

    int tests_run    = 0;
    int tests_failed = 0;
    int sb[$];

    wb_commit_queue #(.DEPTH(8), .AFULL_THR(6)) dut (
        .clk(clk), .rst(rst),
        .WB_Valid(WB_Valid), .WB_PC(WB_PC), .WB_Instr(WB_Instr), .WB_Dst(WB_Dst),
        .WB_Result(WB_Result), .WB_RegsWrType(WB_RegsWrType),
        .Commit_Ready(Commit_Ready), .Commit_Valid(Commit_Valid),
        .Commit_PC(Commit_PC), .Commit_Instr(Commit_Instr), .Commit_Wen(Commit_Wen),
        .Commit_Wnum(Commit_Wnum), .Commit_Wdata(Commit_Wdata), .Commit_Stall(Commit_Stall),
        .Commit_Overflow(Commit_Overflow), .Commit_Count(Commit_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] e_pc(input int k);     return 32'(32'h0000_1000 + k * 4); endfunction
    function automatic logic [31:0] e_instr(input int k);  return 32'h2400_0000 | 32'(k);    endfunction
    function automatic logic [4:0]  e_dst(input int k);    return 5'((k % 31) + 1);          endfunction
    function automatic logic [31:0] e_res(input int k);    return 32'hA000_0000 + 32'(k);    endfunction
    function automatic logic        e_rfwr(input int k);   return (k % 5) != 3;              endfunction

    task automatic set_wb(input int k);
        WB_Valid           = 1'b1;
        WB_PC              = e_pc(k);
        WB_Instr           = e_instr(k);
        WB_Dst             = e_dst(k);
        WB_Result          = e_res(k);
        WB_RegsWrType      = '{RFWr: e_rfwr(k), HIWr: 1'b0, LOWr: 1'b0, CP0Wr: 1'b0};
    endtask

    task automatic check_head(input string tag, input int k);
        check({tag, "_valid"}, 64'(Commit_Valid), 64'd1);
        check({tag, "_pc"},    64'(Commit_PC),    64'(e_pc(k)));
        check({tag, "_instr"}, 64'(Commit_Instr), 64'(e_instr(k)));
        check({tag, "_wen"},   64'(Commit_Wen),   e_rfwr(k) ? 64'hF : 64'h0);
        check({tag, "_wnum"},  64'(Commit_Wnum),  e_rfwr(k) ? 64'(e_dst(k)) : 64'd0);
        check({tag, "_wdata"}, 64'(Commit_Wdata), e_rfwr(k) ? 64'(e_res(k)) : 64'd0);
    endtask

    initial begin
        rst = 1'b0; WB_Valid = 1'b1; Commit_Ready = 1'b0;
        WB_PC = 32'h0; WB_Instr = 32'h0; WB_Dst = 5'd0; WB_Result = 32'h0;
        WB_RegsWrType = '{RFWr: 1'b1, HIWr: 1'b0, LOWr: 1'b0, CP0Wr: 1'b0};

        // 1: reset held with WB_Valid high
        repeat (3) tick();
        check("rst_valid", 64'(Commit_Valid), 64'd0);
        check("rst_count", Commit_Count, 64'd0);
        check("rst_ovf",   64'(Commit_Overflow), 64'd0);
        check("rst_stall", 64'(Commit_Stall), 64'd0);
        rst = 1'b1; WB_Valid = 1'b0;
        tick();
        check("idle_valid", 64'(Commit_Valid), 64'd0);
        check("idle_pc",    64'(Commit_PC), 64'd0);

        // 2: single push, one-cycle latency, then pop
        WB_Valid = 1'b1; WB_PC = 32'hBFC0_0000; WB_Instr = 32'h2408_0005;
        WB_Dst = 5'd8; WB_Result = 32'd5;
        WB_RegsWrType = '{RFWr: 1'b1, HIWr: 1'b0, LOWr: 1'b0, CP0Wr: 1'b0};
        #1;
        check("nobypass_valid", 64'(Commit_Valid), 64'd0);
        tick();
        check("p1_valid", 64'(Commit_Valid), 64'd1);
        check("p1_pc",    64'(Commit_PC), 64'hBFC0_0000);
        check("p1_instr", 64'(Commit_Instr), 64'h2408_0005);
        check("p1_wen",   64'(Commit_Wen), 64'hF);
        check("p1_wnum",  64'(Commit_Wnum), 64'd8);
        check("p1_wdata", 64'(Commit_Wdata), 64'd5);
        WB_Valid = 1'b0; Commit_Ready = 1'b1;
        tick();
        check("p1_count", Commit_Count, 64'd1);
        check("p1_empty", 64'(Commit_Valid), 64'd0);

        // 3: write to $zero is masked
        Commit_Ready = 1'b0; WB_Valid = 1'b1; WB_Dst = 5'd0; WB_Result = 32'hDEAD;
        tick();
        check("z_valid", 64'(Commit_Valid), 64'd1);
        check("z_wen",   64'(Commit_Wen), 64'h0);
        check("z_wnum",  64'(Commit_Wnum), 64'd0);
        check("z_wdata", 64'(Commit_Wdata), 64'd0);
        WB_Valid = 1'b0; Commit_Ready = 1'b1;
        tick();
        check("z_count", Commit_Count, 64'd2);

        // 4: fill to 8 with Ready low, stall at 6, 9th push dropped
        Commit_Ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_wb(i);
            tick();
            sb.push_back(i);
            check($sformatf("fill_stall%0d", i), 64'(Commit_Stall), (i + 1 >= 6) ? 64'd1 : 64'd0);
        end
        check("full_ovf0", 64'(Commit_Overflow), 64'd0);
        set_wb(8);
        tick();
        check("drop_ovf", 64'(Commit_Overflow), 64'd1);
        check_head("drop_head", sb[0]);

        // 5: full queue, push and pop every cycle for 20 cycles across the wrap
        Commit_Ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            set_wb(9 + c);
            check($sformatf("wrap_pc%0d", c), 64'(Commit_PC), 64'(e_pc(sb[0])));
            check($sformatf("wrap_wd%0d", c), 64'(Commit_Wdata), e_rfwr(sb[0]) ? 64'(e_res(sb[0])) : 64'd0);
            tick();
            void'(sb.pop_front());
            sb.push_back(9 + c);
        end
        check("wrap_count", Commit_Count, 64'd22);
        check("wrap_ovf",   64'(Commit_Overflow), 64'd1);
        check("wrap_stall", 64'(Commit_Stall), 64'd1);
        WB_Valid = 1'b0;
        for (int d = 0; d < 8; d++) begin
            check_head($sformatf("drain%0d", d), sb[0]);
            tick();
            void'(sb.pop_front());
            check($sformatf("drain_stall%0d", d), 64'(Commit_Stall), (sb.size() >= 6) ? 64'd1 : 64'd0);
        end
        check("drain_valid", 64'(Commit_Valid), 64'd0);
        check("drain_count", Commit_Count, 64'd30);

        // 6: reset with 5 queued entries
        Commit_Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_wb(40 + i);
            tick();
        end
        WB_Valid = 1'b0; rst = 1'b0;
        tick();
        check("mid_rst_valid", 64'(Commit_Valid), 64'd0);
        check("mid_rst_count", Commit_Count, 64'd0);
        check("mid_rst_ovf",   64'(Commit_Overflow), 64'd0);
        check("mid_rst_stall", 64'(Commit_Stall), 64'd0);
        rst = 1'b1;
        tick();
        check("post_rst_valid", 64'(Commit_Valid), 64'd0);
        set_wb(50);
        tick();
        WB_Valid = 1'b0;
        check_head("fresh", 50);
        Commit_Ready = 1'b1;
        tick();
        check("fresh_count", Commit_Count, 64'd1);
        check("fresh_empty", 64'(Commit_Valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
